// File: rtl/frame_align.sv
// frame_align: hunts for the 6-byte FAS in an unaligned byte stream, confirms it
// over consecutive frames, tracks row/column while locked and declares loss of
// frame after repeated FAS misses.
module frame_align #(
  parameter int unsigned SYNC_FRAMES = 2,
  parameter int unsigned LOSS_FRAMES = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_data_valid,
  output logic        o_frame_data_fas,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic        o_in_frame,
  output logic        o_lof_event
);

  localparam int unsigned COL_W   = 11;
  localparam int unsigned ROW_W   = 2;
  localparam int unsigned HIST_W  = 48;
  localparam int unsigned CONF_W  = $clog2(SYNC_FRAMES + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_FRAMES + 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(1040);
  localparam logic [COL_W-1:0]  COL_CHECK = COL_W'(5);
  localparam logic [COL_W-1:0]  COL_AFTER = COL_W'(6);
  localparam logic [HIST_W-1:0] FAS       = 48'hF6F6F6_282828;
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(SYNC_FRAMES - 1);
  localparam logic [CONF_W-1:0] CONF_TERM = CONF_W'(SYNC_FRAMES);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_FRAMES - 1);
  localparam logic [MISS_W-1:0] MISS_TERM = MISS_W'(LOSS_FRAMES);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_t;

  state_t              r_state;
  logic [HIST_W-1:0]   r_hist;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic [CONF_W-1:0]   r_conf;
  logic [MISS_W-1:0]   r_miss;

  logic [HIST_W-1:0]   w_hist_next;
  logic                w_match;
  logic                w_at_check;
  logic                w_in_fas;
  logic [ROW_W-1:0]    w_row_next;
  logic [COL_W-1:0]    w_col_next;

  // History including the current byte, and position decode of the current byte
  assign w_hist_next = {r_hist[HIST_W-9:0], i_data};
  assign w_match     = (w_hist_next == FAS);
  assign w_at_check  = (r_row == '0) && (r_col == COL_CHECK);
  assign w_in_fas    = (r_row == '0) && (r_col <= COL_CHECK);
  assign w_col_next  = (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
  assign w_row_next  = (r_col == COL_LAST) ? r_row + ROW_W'(1) : r_row;

  // Alignment FSM, position counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state            <= HUNT;
      r_hist             <= '0;
      r_row              <= '0;
      r_col              <= '0;
      r_conf             <= '0;
      r_miss             <= '0;
      o_frame_data       <= '0;
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_row_cnt          <= '0;
      o_col_cnt          <= '0;
      o_in_frame         <= 1'b0;
      o_lof_event        <= 1'b0;
    end else begin
      o_lof_event <= 1'b0;
      if (i_data_valid) begin
        r_hist             <= w_hist_next;
        o_frame_data       <= i_data;
        o_frame_data_valid <= (r_state == SYNC);
        o_frame_data_fas   <= (r_state == SYNC) && w_in_fas;
        o_row_cnt          <= (r_state == HUNT) ? '0 : r_row;
        o_col_cnt          <= (r_state == HUNT) ? '0 : r_col;
        r_row              <= w_row_next;
        r_col              <= w_col_next;
        case (r_state)
          HUNT: begin
            // A match pins the current byte to row 0 col 5
            if (w_match) begin
              r_row   <= '0;
              r_col   <= COL_AFTER;
              r_conf  <= '0;
              r_state <= PRESYNC;
            end
          end
          PRESYNC: begin
            if (w_at_check) begin
              if (!w_match) begin
                r_state <= HUNT;
              end else if (r_conf >= CONF_LAST) begin
                r_conf     <= CONF_TERM;
                r_miss     <= '0;
                r_state    <= SYNC;
                o_in_frame <= 1'b1;
              end else begin
                r_conf <= r_conf + CONF_W'(1);
              end
            end
          end
          SYNC: begin
            if (w_at_check) begin
              if (w_match) begin
                r_miss <= '0;
              end else if (r_miss >= MISS_LAST) begin
                r_miss      <= '0;
                r_state     <= HUNT;
                o_in_frame  <= 1'b0;
                o_lof_event <= 1'b1;
              end else begin
                r_miss <= r_miss + MISS_W'(1);
              end
            end
          end
          default: begin
            r_state    <= HUNT;
            o_in_frame <= 1'b0;
          end
        endcase
      end else begin
        o_frame_data_valid <= 1'b0;
        o_frame_data_fas   <= 1'b0;
      end
    end
  end

  // MISS_TERM documents the saturation bound of the miss counter
  logic w_unused;
  assign w_unused = ^MISS_TERM;

endmodule

// File: tb/tb_frame_align.sv
// tb_frame_align: directed frame streams; expected output bytes are queued as
// they are driven and a monitor pops and compares each valid output byte.
module tb_frame_align;

  localparam int unsigned COLS  = 1041;
  localparam int unsigned FRAME = 4164;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_data_valid;
  logic [7:0]  o_frame_data;
  logic        o_frame_data_valid;
  logic        o_frame_data_fas;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic        o_in_frame;
  logic        o_lof_event;

  frame_align dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_data             (i_data),
    .i_data_valid       (i_data_valid),
    .o_frame_data       (o_frame_data),
    .o_frame_data_valid (o_frame_data_valid),
    .o_frame_data_fas   (o_frame_data_fas),
    .o_row_cnt          (o_row_cnt),
    .o_col_cnt          (o_col_cnt),
    .o_in_frame         (o_in_frame),
    .o_lof_event        (o_lof_event)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic [1:0]  r;
    logic [10:0] c;
    logic        fas;
  } exp_t;

  exp_t q[$];
  exp_t e_head;
  exp_t e_got;
  int   checks     = 0;
  int   errors     = 0;
  int   lof_cycles = 0;
  bit   gap        = 1'b0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1500000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  // Monitor: every valid output byte must match the head of the queue
  always @(negedge i_clk) begin
    if (o_lof_event) lof_cycles++;
    if (o_frame_data_valid) begin
      checks++;
      e_got = '{o_frame_data, o_row_cnt, o_col_cnt, o_frame_data_fas};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got data %0h row %0d col %0d, required no valid output",
                 o_frame_data, o_row_cnt, o_col_cnt);
      end else begin
        e_head = q.pop_front();
        if (e_got != e_head) begin
          errors++;
          $display("FAIL out_byte got d=%0h r=%0d c=%0d fas=%0d required d=%0h r=%0d c=%0d fas=%0d",
                   e_got.d, e_got.r, e_got.c, e_got.fas, e_head.d, e_head.r, e_head.c, e_head.fas);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic put(input logic [7:0] d, input bit v);
    i_data       = d;
    i_data_valid = v;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int r, input int c, input bit ex);
    if (ex) q.push_back('{d, 2'(r), 11'(c), (r == 0 && c <= 5)});
    put(d, 1'b1);
    if (gap) put(8'hF6, 1'b0);
  endtask

  // mode: 0 none expected, 1 all, 2 lock frame (from col 6), 3 loss frame (up to col 5)
  task automatic send_frame(input bit corrupt, input int mode, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      int r;
      int c;
      logic [7:0] d;
      bit ex;
      r = i / COLS;
      c = i % COLS;
      if (r == 0 && c < 6) d = (c < 3) ? 8'hF6 : ((c == 3 && corrupt) ? 8'h29 : 8'h28);
      else d = 8'((c + 3 * r) % 128);
      case (mode)
        0:       ex = 1'b0;
        1:       ex = 1'b1;
        2:       ex = (i >= 6);
        default: ex = (i <= 5);
      endcase
      send(d, r, c, ex);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  int'(o_frame_data), 0);
    chk({tag, "_valid"}, int'(o_frame_data_valid), 0);
    chk({tag, "_fas"},   int'(o_frame_data_fas), 0);
    chk({tag, "_row"},   int'(o_row_cnt), 0);
    chk({tag, "_col"},   int'(o_col_cnt), 0);
    chk({tag, "_inf"},   int'(o_in_frame), 0);
    chk({tag, "_lof"},   int'(o_lof_event), 0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_data = 8'h00;
    i_data_valid = 1'b0;
    put(8'hF6, 1'b1);
    put(8'hF6, 1'b1);
    chk_all_zero("reset");
    i_rst = 1'b0;

    // Clean lock with a 100-byte phase offset
    for (int i = 0; i < 100; i++) send(8'(i % 128), 0, 0, 1'b0);
    send_frame(1'b0, 0, FRAME);
    send_frame(1'b0, 0, FRAME);
    chk("presync_no_lock", int'(o_in_frame), 0);
    send_frame(1'b0, 2, FRAME);
    chk("lock_frame3", int'(o_in_frame), 1);

    // Next frame carries FAS flags, then reset at row 2 col 500
    send_frame(1'b0, 1, 2 * COLS + 500);
    chk("sync_before_rst", int'(o_in_frame), 1);
    i_rst = 1'b1;
    put(8'h28, 1'b1);
    chk_all_zero("midrst");
    i_rst = 1'b0;

    // Re-lock with valid toggling 1,0
    gap = 1'b1;
    send_frame(1'b0, 0, FRAME);
    send_frame(1'b0, 0, FRAME);
    chk("gap_no_lock", int'(o_in_frame), 0);
    send_frame(1'b0, 2, FRAME);
    chk("gap_lock", int'(o_in_frame), 1);
    gap = 1'b0;

    // 4 bad, 1 good, 4 bad: stays in SYNC
    for (int k = 0; k < 4; k++) send_frame(1'b1, 1, FRAME);
    chk("bad4_inframe", int'(o_in_frame), 1);
    chk("bad4_lof", lof_cycles, 0);
    send_frame(1'b0, 1, FRAME);
    for (int k = 0; k < 4; k++) send_frame(1'b1, 1, FRAME);
    chk("bad4g4_inframe", int'(o_in_frame), 1);
    chk("bad4g4_lof", lof_cycles, 0);
    // Fifth consecutive bad frame declares loss; its col-5 byte is still output
    send_frame(1'b1, 3, 40);
    chk("loss_lof_pulse", lof_cycles, 1);
    chk("loss_inframe", int'(o_in_frame), 0);

    // Fake FAS in payload followed directly by true frames
    i_rst = 1'b1;
    put(8'h00, 1'b0);
    i_rst = 1'b0;
    for (int i = 0; i < 50; i++) send(8'(i % 128), 0, 0, 1'b0);
    send(8'hF6, 0, 0, 1'b0);
    send(8'hF6, 0, 0, 1'b0);
    send(8'hF6, 0, 0, 1'b0);
    send(8'h28, 0, 0, 1'b0);
    send(8'h28, 0, 0, 1'b0);
    send(8'h28, 0, 0, 1'b0);
    send_frame(1'b0, 0, FRAME);
    send_frame(1'b0, 0, FRAME);
    send_frame(1'b0, 0, FRAME);
    chk("fake_no_lock", int'(o_in_frame), 0);
    send_frame(1'b0, 2, 60);
    chk("fake_true_lock", int'(o_in_frame), 1);

    put(8'h00, 1'b0);
    put(8'h00, 1'b0);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_align.md
FRAME_ALIGN -- requirements
Module: frame_align

Interface
REQ-001 Parameter SYNC_FRAMES, default 2, number of consecutive confirmed FAS frames needed to go from PRESYNC to SYNC.
REQ-002 Parameter LOSS_FRAMES, default 5, number of consecutive missed FAS frames in SYNC that declare loss of frame.
REQ-003 i_clk  in  1  clock; all logic is rising-edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_data  in  8  unaligned line byte stream.
REQ-006 i_data_valid  in  1  qualifies i_data; counters and history advance only on valid cycles.
REQ-007 o_frame_data  out  8  registered copy of i_data.
REQ-008 o_frame_data_valid  out  1  high for bytes passed while in SYNC.
REQ-009 o_frame_data_fas  out  1  high on output bytes at row 0, cols 0..5, while in SYNC.
REQ-010 o_row_cnt  out  2  row (0..3) of the output byte.
REQ-011 o_col_cnt  out  11  column (0..1040) of the output byte.
REQ-012 o_in_frame  out  1  high while the state is SYNC.
REQ-013 o_lof_event  out  1  one-cycle pulse on the SYNC->HUNT transition.

Function
REQ-014 Frame: 4 rows x 1041 cols (0..1040), 4164 bytes; FAS = F6 F6 F6 28 28 28 at row 0, cols 0..5.
REQ-015 Position counter: col increments per valid byte; col 1040 wraps to 0 with row+1; row 3 col 1040 wraps to row 0 col 0.
REQ-016 A 48-bit history shifts in i_data on every valid cycle; "match" = history including the current byte equals FAS.
REQ-017 States: HUNT, PRESYNC, SYNC.
REQ-018 HUNT: check match on every valid byte; on match, the current byte is row 0 col 5, the next position is col 6, the confirm count clears, and the state goes to PRESYNC.
REQ-019 PRESYNC: check only when the current valid byte is at row 0 col 5; match increments the confirm count, mismatch returns to HUNT.
REQ-020 PRESYNC to SYNC happens on the check edge where the confirm count reaches SYNC_FRAMES.
REQ-021 SYNC: check at row 0 col 5; match clears the miss count, mismatch increments it.
REQ-022 When the miss count reaches LOSS_FRAMES: go to HUNT, pulse o_lof_event for 1 cycle, clear the miss count.
REQ-023 Counters free-run in PRESYNC and SYNC; in HUNT they are don't-care internally and o_row_cnt/o_col_cnt output 0.
REQ-024 Latency is 1 cycle: the output registers load from the current input byte and the pre-edge state and position.
REQ-025 o_frame_data_valid = i_data_valid AND (pre-edge state == SYNC).
REQ-026 The first valid output after lock is row 0 col 6 of the confirming frame.
REQ-027 The col-5 byte on which loss is declared is still output valid.
REQ-028 On cycles with i_data_valid low: o_frame_data_valid and o_frame_data_fas are 0, o_frame_data holds, no counter or state change.
REQ-029 A false FAS pattern in the payload during HUNT enters PRESYNC and is rejected by the next frame's check.
REQ-030 In HUNT, a match on the same edge as the SYNC->HUNT transition is ignored; hunting starts on the following valid byte.
REQ-031 Count widths hold LOSS_FRAMES and SYNC_FRAMES without overflow; counts saturate at their terminal value.

Reset
REQ-032 On i_rst all outputs go to 0 on the next edge, regardless of i_data_valid.
REQ-033 On i_rst the state goes to HUNT, history and counts go to 0, and the position goes to row 0 col 0.
REQ-034 Reset mid-frame in any state behaves identically to reset from idle; no partial lock is retained.

Verification
REQ-035 Reset, then 3 clean frames with phase offset 100 bytes -> o_in_frame rises after frame-3 row 0 col 5; first valid output is row 0 col 6 with o_row_cnt=0, o_col_cnt=6; frame 4 cols 0..5 have fas=1 and data F6,F6,F6,28,28,28.
REQ-036 In SYNC, corrupt byte col 3 (28->29) in 4 consecutive frames -> o_in_frame stays 1; a 5th consecutive corruption -> o_lof_event=1 for 1 cycle, then o_in_frame=0 and o_frame_data_valid=0.
REQ-037 In SYNC, 4 bad frames, 1 good frame, 4 bad frames -> no o_lof_event and o_in_frame stays 1.
REQ-038 Insert a fake FAS in the payload before the true frames; the next frame at that offset has no FAS -> PRESYNC returns to HUNT, and lock is reached on the true FAS 2 frames later.
REQ-039 i_data_valid toggling 1,0,1,0 through clean frames -> same lock sequence as REQ-035; counters change only after valid bytes; valid-low cycles give o_frame_data_valid=0.
REQ-040 Assert i_rst at row 2 col 500 in SYNC -> all outputs 0 on the next cycle; re-lock requires 3 full FAS frames.
